// File: rtl/seg_frame_arbiter_if.sv
// Display-share bus between the requesters and seg_frame_arbiter.
// master = requester side (drives req/data/mask), slave = arbiter side.
interface seg_frame_arbiter_if #(
    parameter int NREQ = 3,
    parameter int NDIG = 6
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_i;
    logic [NREQ*NDIG*4-1:0] data_i;
    logic [NREQ*NDIG-1:0]   mask_i;
    logic [NREQ-1:0]        gnt_o;
    logic [OW-1:0]          owner_o;
    logic                   busy_o;
    logic [NDIG*4-1:0]      digits_o;
    logic [NDIG-1:0]        valid_o;

    modport master (output req_i, data_i, mask_i,
                    input  gnt_o, owner_o, busy_o, digits_o, valid_o);
    modport slave  (input  req_i, data_i, mask_i,
                    output gnt_o, owner_o, busy_o, digits_o, valid_o);
endinterface

// File: rtl/seg_frame_arbiter.sv
// Round-robin arbiter sharing the 7-seg display between NREQ requesters,
// with a minimum hold time per owner and registered frame forwarding.
// Optional macro SEG_ARB_BLANK_EN: insert BLANK blanking cycles on every
// owner change (display dark, busy held) before the next grant.
module seg_frame_arbiter #(
    parameter int NREQ  = 3,
    parameter int NDIG  = 6,
    parameter int HOLD  = 50000,
    parameter int BLANK = 1000
) (
    input  logic               clk,
    input  logic               rstn,
    seg_frame_arbiter_if.slave bus
);
    localparam int OW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    // one counter serves both the hold time and the blanking interval
    localparam int MAXC = (HOLD > BLANK) ? HOLD : BLANK;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {S_IDLE, S_OWN, S_BLANK} state_t;

    state_t            r_state, w_state_n;
    logic [NREQ-1:0]   r_gnt, w_gnt_n;
    logic [OW-1:0]     r_owner, w_owner_n;
    logic [OW-1:0]     r_last, w_last_n;
    logic              r_busy, w_busy_n;
    logic [NDIG*4-1:0] r_dig, w_dig_n;
    logic [NDIG-1:0]   r_val, w_val_n;
    logic [CW-1:0]     r_cnt, w_cnt_n;

    logic [NREQ-1:0]   w_excl;
    logic [OW:0]       w_pick;
    logic              w_found;
    logic [OW-1:0]     w_idx;
    logic              w_own_req;
    logic              w_do_grant;

    // First requester set in rq, scanning from last+1 upward with wrap.
    function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] rq,
                                            input logic [OW-1:0]   last);
        logic          found;
        logic [OW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            k = (int'(last) + i) % NREQ;
            if (!found && rq[k]) begin
                found = 1'b1;
                idx   = OW'(k);
            end
        end
        return {found, idx};
    endfunction

    // While owning, the current owner is excluded so a contested switch
    // always moves to someone else.
    always_comb begin
        w_excl    = (r_state == S_OWN) ? (NREQ'(1) << r_owner) : '0;
        w_pick    = rr_pick(bus.req_i & ~w_excl, r_last);
        w_found   = w_pick[OW];
        w_idx     = w_pick[OW-1:0];
        w_own_req = bus.req_i[r_owner];
    end

    // Next-state and output logic.
    always_comb begin
        w_state_n  = r_state;
        w_gnt_n    = r_gnt;
        w_owner_n  = r_owner;
        w_last_n   = r_last;
        w_busy_n   = r_busy;
        w_dig_n    = r_dig;
        w_val_n    = r_val;
        w_cnt_n    = r_cnt;
        w_do_grant = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_dig_n    = '0;
                w_val_n    = '0;
                w_do_grant = w_found;
            end
            S_OWN: begin
                w_dig_n = bus.data_i[int'(r_owner)*NDIG*4 +: NDIG*4];
                w_val_n = bus.mask_i[int'(r_owner)*NDIG +: NDIG];
                w_cnt_n = (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                if (!w_own_req || (r_cnt == '0 && w_found)) begin
                    // release or contested switch: display goes dark this edge
                    w_gnt_n   = '0;
                    w_busy_n  = 1'b0;
                    w_dig_n   = '0;
                    w_val_n   = '0;
                    w_state_n = S_IDLE;
`ifdef SEG_ARB_BLANK_EN
                    if (w_found) begin
                        w_busy_n  = 1'b1;
                        w_cnt_n   = CW'(BLANK - 1);
                        w_state_n = S_BLANK;
                    end
`else
                    w_do_grant = w_found;
`endif
                end
            end
            S_BLANK: begin
                w_gnt_n = '0;
                w_dig_n = '0;
                w_val_n = '0;
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - 1'b1;
                end else begin
                    // winner re-evaluated from live request levels
                    w_busy_n   = 1'b0;
                    w_state_n  = S_IDLE;
                    w_do_grant = w_found;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
        if (w_do_grant) begin
            w_gnt_n   = NREQ'(1) << w_idx;
            w_owner_n = w_idx;
            w_last_n  = w_idx;
            w_busy_n  = 1'b1;
            w_cnt_n   = CW'(HOLD - 1);
            w_state_n = S_OWN;
        end
    end

    // State and output registers, async active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= OW'(NREQ - 1);
            r_busy  <= 1'b0;
            r_dig   <= '0;
            r_val   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_gnt   <= w_gnt_n;
            r_owner <= w_owner_n;
            r_last  <= w_last_n;
            r_busy  <= w_busy_n;
            r_dig   <= w_dig_n;
            r_val   <= w_val_n;
            r_cnt   <= w_cnt_n;
        end
    end

    assign bus.gnt_o    = r_gnt;
    assign bus.owner_o  = r_owner;
    assign bus.busy_o   = r_busy;
    assign bus.digits_o = r_dig;
    assign bus.valid_o  = r_val;
endmodule

// File: tb/tb_seg_frame_arbiter.sv
// Directed bench for seg_frame_arbiter (NREQ=3, NDIG=6, HOLD=4, BLANK=2).
module tb_seg_frame_arbiter;
    logic        clk;
    logic        rstn;
    logic [2:0]  req;
    logic [23:0] d0, d1, d2;
    logic [5:0]  m0, m1, m2;
    int          checks;
    int          errors;

    seg_frame_arbiter_if #(.NREQ(3), .NDIG(6)) bus ();

    seg_frame_arbiter #(.NREQ(3), .NDIG(6), .HOLD(4), .BLANK(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    assign bus.req_i  = req;
    assign bus.data_i = {d2, d1, d0};
    assign bus.mask_i = {m2, m1, m0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn = 1'b0;
        req  = 3'b000;
        d0 = 24'h123456; m0 = 6'h3F;
        d1 = 24'h000001; m1 = 6'h01;
        d2 = 24'hABCDEF; m2 = 6'h2A;
        tick(); tick();
        rstn = 1'b1;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_gnt",   32'(bus.gnt_o), 32'h0);
            chk("rst_busy",  32'(bus.busy_o), 32'h0);
            chk("rst_frame", {2'b0, bus.valid_o, bus.digits_o}, 32'h0);
            chk("rst_owner", 32'(bus.owner_o), 32'h0);
        end

        // req0+req2: 0 wins first, alternates every 4 cycles
        req = 3'b101;
        tick();
        chk("g0_gnt",   32'(bus.gnt_o), 32'h1);
        chk("g0_busy",  32'(bus.busy_o), 32'h1);
        chk("g0_owner", 32'(bus.owner_o), 32'h0);
        tick();
        chk("g0_dig", 32'(bus.digits_o), 32'h123456);
        chk("g0_val", 32'(bus.valid_o), 32'h3F);
        chk("g0_hold1", 32'(bus.gnt_o), 32'h1);
        tick(); chk("g0_hold2", 32'(bus.gnt_o), 32'h1);
        tick(); chk("g0_hold3", 32'(bus.gnt_o), 32'h1);
        tick();
        chk("g2_gnt",   32'(bus.gnt_o), 32'h4);
        chk("g2_owner", 32'(bus.owner_o), 32'h2);
        tick();
        chk("g2_dig", 32'(bus.digits_o), 32'hABCDEF);
        chk("g2_val", 32'(bus.valid_o), 32'h2A);
        tick(); tick();
        chk("g2_hold", 32'(bus.gnt_o), 32'h4);
        tick();
        chk("back0_gnt", 32'(bus.gnt_o), 32'h1);

        // release with nobody waiting
        req = 3'b000;
        tick();
        chk("rel_gnt",   32'(bus.gnt_o), 32'h0);
        chk("rel_busy",  32'(bus.busy_o), 32'h0);
        chk("rel_frame", {2'b0, bus.valid_o, bus.digits_o}, 32'h0);

        // sole requester 1, live data tracking
        req = 3'b010;
        tick();
        chk("s1_gnt", 32'(bus.gnt_o), 32'h2);
        tick();
        chk("s1_dig1", 32'(bus.digits_o), 32'h000001);
        d1 = 24'h000002;
        tick();
        chk("s1_dig2", 32'(bus.digits_o), 32'h000002);
        d1 = 24'h000003;
        tick();
        chk("s1_dig3", 32'(bus.digits_o), 32'h000003);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("s1_keep", 32'(bus.gnt_o), 32'h2);
        end

        // owner drop overrides hold, same-edge regrant to pending req2
        req = 3'b000;
        tick();
        chk("s1_rel", 32'(bus.gnt_o), 32'h0);
        req = 3'b001;                      // last=1: 0 wins
        tick();
        chk("d0_gnt", 32'(bus.gnt_o), 32'h1);
        req = 3'b101;                      // hold not expired: stays 0
        tick();
        chk("d0_keep", 32'(bus.gnt_o), 32'h1);
        req = 3'b100;                      // owner drops
        tick();
        chk("d2_gnt",   32'(bus.gnt_o), 32'h4);
        chk("d2_owner", 32'(bus.owner_o), 32'h2);
        chk("d2_frame", {2'b0, bus.valid_o, bus.digits_o}, 32'h0);
        tick();
        chk("d2_dig", 32'(bus.digits_o), 32'hABCDEF);

        // all three: order 0,1,2,0,... each held 4 cycles
        req = 3'b000;
        tick();
        chk("a_idle", 32'(bus.gnt_o), 32'h0);
        req = 3'b111;                      // last=2: 0 wins
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("a_gnt",   32'(bus.gnt_o), 32'(3'b001 << ((k / 4) % 3)));
            chk("a_owner", 32'(bus.owner_o), 32'((k / 4) % 3));
        end

        // explicit 0->1 switch from a fresh reset
        req  = 3'b000;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req  = 3'b011;
        tick(); chk("sw_g0", 32'(bus.gnt_o), 32'h1);
        tick(); tick(); tick();
        chk("sw_g0_last", 32'(bus.gnt_o), 32'h1);
        tick();
`ifdef SEG_ARB_BLANK_EN
        chk("bl_gnt1", 32'(bus.gnt_o), 32'h0);
        chk("bl_busy1", 32'(bus.busy_o), 32'h1);
        chk("bl_val1", 32'(bus.valid_o), 32'h0);
        tick();
        chk("bl_gnt2", 32'(bus.gnt_o), 32'h0);
        chk("bl_busy2", 32'(bus.busy_o), 32'h1);
        tick();
        chk("bl_g1", 32'(bus.gnt_o), 32'h2);
`else
        chk("sw_g1", 32'(bus.gnt_o), 32'h2);
`endif
        tick();
        chk("sw_val1", 32'(bus.valid_o), 32'h01);

        // async reset mid-grant
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("ar_gnt",  32'(bus.gnt_o), 32'h0);
        chk("ar_busy", 32'(bus.busy_o), 32'h0);
        chk("ar_val",  32'(bus.valid_o), 32'h0);
        chk("ar_dig",  32'(bus.digits_o), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
